harris_corner_logger: RTL and testbench

// - Synthesizable successor to the simulation-only Harris score printer; sits after the Harris response stage.
// - Per frame, keeps every pixel whose signed score R >= threshold as a record {score,x,y}.
// - Records are buffered in a FIFO and drained over a valid/ready stream.
// - Reports per-frame corner count, drop count and the peak score with its location.

---
 rtl/harris_corner_logger_pkg.sv | 22 ++
 rtl/harris_corner_logger_corner_fifo.sv | 83 ++++++++
 rtl/harris_corner_logger.sv | 203 ++++++++++++++++++++
 tb/tb_harris_corner_logger.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/harris_corner_logger_pkg.sv
// Shared types and defaults for the Harris corner logger.
// - SCORE_W_DEF / COORD_W_DEF: default score and coordinate widths.
// - corner_rec_t: one buffered corner record, score in the MSBs, then x, then y.
// - logger_state_t: frame tracking state of the logger.
package harris_corner_logger_pkg;

  localparam int SCORE_W_DEF = 64;
  localparam int COORD_W_DEF = 16;

  typedef struct packed {
    logic [SCORE_W_DEF-1:0] score;
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } corner_rec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } logger_state_t;

endpackage

// File: rtl/harris_corner_logger_corner_fifo.sv
// corner_fifo: synchronous first-word-fall-through FIFO for corner records.
// Ports:
//   clk, reset      clock, synchronous active-low reset (empties the FIFO)
//   push, push_data write request and record; accepted when not full, or when
//                   a pop happens in the same cycle
//   pop             remove head record; ignored when empty
//   head_data       current head record, zero while empty
//   full, empty     occupancy flags
//   level           number of records held
module corner_fifo
  import harris_corner_logger_pkg::*;
#(
  parameter int DATA_W = $bits(corner_rec_t),
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [LW-1:0]     level_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests; a push into a full FIFO rides on a simultaneous pop
  always_comb begin
    do_pop_s  = pop && (level_r != LW'(0));
    do_push_s = push && ((level_r != LW'(DEPTH)) || do_pop_s);
  end

  // Record storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Head is forced to zero while empty so stale storage never leaks out
  always_comb begin
    if (level_r == LW'(0)) begin
      head_data = '0;
    end else begin
      head_data = mem_r[rd_ptr_r];
    end
    full  = (level_r == LW'(DEPTH));
    empty = (level_r == LW'(0));
    level = level_r;
  end

endmodule

// File: rtl/harris_corner_logger.sv
// harris_corner_logger: captures every sample whose signed Harris score is at
// or above a per-frame threshold, buffers {score,x,y} records in a FWFT FIFO
// drained over a valid/ready stream, and keeps per-frame statistics.
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   in_valid/in_score/in_x/in_y score sample stream
//   threshold                   signed threshold, latched at frame_start
//   frame_start, frame_end      frame delimiters (pulses)
//   out_valid/out_ready         record stream handshake
//   out_score/out_x/out_y       head record
//   fifo_level                  records buffered
//   corner_count, drop_count    saturating per-frame counters
//   max_valid/max_score/max_x/max_y  peak score of the frame and its location
//   frame_done                  pulse the cycle after an accepted frame_end
module harris_corner_logger
  import harris_corner_logger_pkg::*;
#(
  parameter int SCORE_W    = SCORE_W_DEF,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [SCORE_W-1:0]          in_score,
  input  logic [COORD_W-1:0]          in_x,
  input  logic [COORD_W-1:0]          in_y,
  input  logic [SCORE_W-1:0]          threshold,
  input  logic                        frame_start,
  input  logic                        frame_end,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SCORE_W-1:0]          out_score,
  output logic [COORD_W-1:0]          out_x,
  output logic [COORD_W-1:0]          out_y,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            corner_count,
  output logic [CNT_W-1:0]            drop_count,
  output logic                        max_valid,
  output logic [SCORE_W-1:0]          max_score,
  output logic [COORD_W-1:0]          max_x,
  output logic [COORD_W-1:0]          max_y,
  output logic                        frame_done
);

  localparam int REC_W = SCORE_W + 2 * COORD_W;

  logger_state_t      state_r;
  logger_state_t      state_next_s;
  logic [SCORE_W-1:0] thr_r;
  logic [SCORE_W-1:0] thr_eff_s;
  logic               accept_s;
  logic               end_s;
  logic               corner_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               load_max_s;
  logic               full_s;
  logic               empty_s;
  logic [REC_W-1:0]   push_rec_s;
  logic [REC_W-1:0]   head_rec_s;
  logic [CNT_W-1:0]   corner_count_r;
  logic [CNT_W-1:0]   drop_count_r;
  logic               max_valid_r;
  logic [SCORE_W-1:0] max_score_r;
  logic [COORD_W-1:0] max_x_r;
  logic [COORD_W-1:0] max_y_r;
  logic               frame_done_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Sample acceptance and corner decision; the frame_start cycle already
  // belongs to the new frame and compares against the incoming threshold
  always_comb begin
    accept_s  = 1'b0;
    end_s     = 1'b0;
    thr_eff_s = thr_r;
    if (frame_start) begin
      accept_s  = 1'b1;
      thr_eff_s = threshold;
    end else if (state_r == ACTIVE) begin
      accept_s  = 1'b1;
      end_s     = frame_end;
    end else begin
      accept_s  = 1'b0;
    end
    corner_s   = accept_s && in_valid && ($signed(in_score) >= $signed(thr_eff_s));
    pop_s      = !empty_s && out_ready;
    push_s     = corner_s && (!full_s || pop_s);
    drop_s     = corner_s && !push_s;
    load_max_s = accept_s && in_valid &&
                 (frame_start || !max_valid_r || ($signed(in_score) > $signed(max_score_r)));
    push_rec_s = {in_score, in_x, in_y};
  end

  // Frame state transitions; a frame_start always (re)enters ACTIVE
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) state_next_s = ACTIVE;
        else             state_next_s = IDLE;
      end
      ACTIVE: begin
        if (frame_start)    state_next_s = ACTIVE;
        else if (frame_end) state_next_s = DONE;
        else                state_next_s = ACTIVE;
      end
      DONE: begin
        if (frame_start) state_next_s = ACTIVE;
        else             state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register, threshold latch and frame_done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      thr_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      frame_done_r <= end_s;
      if (frame_start) begin
        thr_r <= threshold;
      end
    end
  end

  // Per-frame corner and drop counters, cleared at frame_start
  always_ff @(posedge clk) begin
    if (!reset) begin
      corner_count_r <= CNT_W'(0);
      drop_count_r   <= CNT_W'(0);
    end else if (frame_start) begin
      corner_count_r <= CNT_W'(corner_s);
      drop_count_r   <= CNT_W'(drop_s);
    end else begin
      if (corner_s) begin
        corner_count_r <= sat_inc(corner_count_r);
      end
      if (drop_s) begin
        drop_count_r <= sat_inc(drop_count_r);
      end
    end
  end

  // Peak tracker: strictly-greater replaces, so ties keep the earliest sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      max_valid_r <= 1'b0;
      max_score_r <= '0;
      max_x_r     <= COORD_W'(0);
      max_y_r     <= COORD_W'(0);
    end else if (load_max_s) begin
      max_valid_r <= 1'b1;
      max_score_r <= in_score;
      max_x_r     <= in_x;
      max_y_r     <= in_y;
    end else if (frame_start) begin
      max_valid_r <= 1'b0;
      max_score_r <= '0;
      max_x_r     <= COORD_W'(0);
      max_y_r     <= COORD_W'(0);
    end else begin
      max_valid_r <= max_valid_r;
    end
  end

  corner_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_rec_s),
    .pop       (pop_s),
    .head_data (head_rec_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  assign out_valid    = !empty_s;
  assign out_score    = head_rec_s[REC_W-1 -: SCORE_W];
  assign out_x        = head_rec_s[2*COORD_W-1 -: COORD_W];
  assign out_y        = head_rec_s[COORD_W-1:0];
  assign corner_count = corner_count_r;
  assign drop_count   = drop_count_r;
  assign max_valid    = max_valid_r;
  assign max_score    = max_score_r;
  assign max_x        = max_x_r;
  assign max_y        = max_y_r;
  assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_harris_corner_logger.sv
// Self-checking bench for harris_corner_logger with a 4-deep FIFO.
// A frame-level reference model predicts statistics and the record stream;
// a negedge monitor pops the expected record queue on each handshake.
module tb_harris_corner_logger;

  localparam int SW    = 64;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [SW-1:0] in_score;
  logic [CW-1:0] in_x;
  logic [CW-1:0] in_y;
  logic [SW-1:0] threshold;
  logic          frame_start;
  logic          frame_end;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_score;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;
  logic [LW-1:0] fifo_level;
  logic [CNTW-1:0] corner_count;
  logic [CNTW-1:0] drop_count;
  logic          max_valid;
  logic [SW-1:0] max_score;
  logic [CW-1:0] max_x;
  logic [CW-1:0] max_y;
  logic          frame_done;

  always #5 clk = ~clk;

  harris_corner_logger #(
    .SCORE_W(SW), .COORD_W(CW), .FIFO_DEPTH(DEPTH), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_score(in_score),
    .in_x(in_x), .in_y(in_y), .threshold(threshold),
    .frame_start(frame_start), .frame_end(frame_end),
    .out_valid(out_valid), .out_ready(out_ready), .out_score(out_score),
    .out_x(out_x), .out_y(out_y), .fifo_level(fifo_level),
    .corner_count(corner_count), .drop_count(drop_count),
    .max_valid(max_valid), .max_score(max_score), .max_x(max_x), .max_y(max_y),
    .frame_done(frame_done)
  );

  typedef struct {
    longint s;
    int     x;
    int     y;
  } rec_t;

  rec_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  // reference model state
  bit     m_in_frame;
  longint m_thr;
  int     m_cc, m_dc, m_level, m_mx, m_my;
  bit     m_mv, m_done;
  longint m_ms;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // stream monitor: every accepted head record must match the oldest expected one
  always @(negedge clk) begin : monitor
    rec_t r;
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL stream_extra: got record score 0x%0h, expected no record", out_score);
      end else begin
        r = exp_q.pop_front();
        check("stream_score", out_score, r.s);
        check("stream_x", {48'd0, out_x}, r.x);
        check("stream_y", {48'd0, out_y}, r.y);
      end
    end
  end

  task automatic check_all();
    check("fifo_level",   {{(64-LW){1'b0}}, fifo_level}, m_level);
    check("out_valid",    {63'd0, out_valid}, m_level > 0);
    check("corner_count", {48'd0, corner_count}, m_cc);
    check("drop_count",   {48'd0, drop_count}, m_dc);
    check("max_valid",    {63'd0, max_valid}, m_mv);
    check("max_score",    max_score, m_ms);
    check("max_x",        {48'd0, max_x}, m_mx);
    check("max_y",        {48'd0, max_y}, m_my);
    check("frame_done",   {63'd0, frame_done}, m_done);
  endtask

  // one clock of stimulus: drive, advance the model, clock, compare
  task automatic step(input bit fs, input bit fe, input bit iv, input longint sc,
                      input int x, input int y, input longint thr, input bit rdy);
    bit pop;
    frame_start = fs;
    frame_end   = fe;
    in_valid    = iv;
    in_score    = sc;
    in_x        = x[15:0];
    in_y        = y[15:0];
    threshold   = thr;
    out_ready   = rdy;
    pop = (m_level > 0) && rdy;
    if (fs) begin
      m_thr = thr; m_cc = 0; m_dc = 0; m_mv = 0; m_ms = 0; m_mx = 0; m_my = 0;
      m_in_frame = 1;
    end
    if ((fs || m_in_frame) && iv) begin
      if (sc >= m_thr) begin
        if (m_cc < CMAX) m_cc++;
        if (m_level < DEPTH || pop) begin
          exp_q.push_back('{sc, x & 16'hFFFF, y & 16'hFFFF});
          m_level++;
        end else if (m_dc < CMAX) begin
          m_dc++;
        end
      end
      if (!m_mv || sc > m_ms) begin
        m_mv = 1; m_ms = sc; m_mx = x & 16'hFFFF; m_my = y & 16'hFFFF;
      end
    end
    if (pop) m_level--;
    m_done = !fs && m_in_frame && fe;
    if (m_done) m_in_frame = 0;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * DEPTH && m_level > 0; i++) idle(1);
    check("drain_empty", {{(64-LW){1'b0}}, fifo_level}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    frame_start = 0; frame_end = 0; in_valid = 0; out_ready = 0;
    in_score = '0; in_x = '0; in_y = '0; threshold = '0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_in_frame = 0; m_thr = 0; m_cc = 0; m_dc = 0; m_level = 0;
    m_mv = 0; m_ms = 0; m_mx = 0; m_my = 0; m_done = 0;
    check_all();
    reset = 1'b1;
  endtask

  function automatic longint rnd_score();
    int k = int'($urandom_range(0, 9));
    if (k == 0) return {$urandom, $urandom};
    return longint'($urandom_range(0, 600)) - 64'sd300;
  endfunction

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    longint thr;
    int len;
    bit fs, fe;
    do_reset();

    // threshold 100, scores {99,100,-5,300}
    step(1, 0, 0, 0, 0, 0, 100, 0);
    step(0, 0, 1, 99, 0, 7, 0, 0);
    step(0, 0, 1, 100, 1, 7, 0, 0);
    step(0, 0, 1, -5, 2, 7, 0, 0);
    step(0, 1, 1, 300, 3, 7, 0, 0);
    check("t1_corner_count", {48'd0, corner_count}, 2);
    check("t1_max_score", max_score, 300);
    check("t1_max_x", {48'd0, max_x}, 3);
    check("t1_frame_done", {63'd0, frame_done}, 1);
    check("t1_head_score", out_score, 100);
    check("t1_head_x", {48'd0, out_x}, 1);
    idle(0);
    check("t1_done_pulse", {63'd0, frame_done}, 0);
    drain();

    // overflow: 6 corners into 4 slots, then full + pop + push
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 10 + i, i, 1, 0, 0);
    check("t2_level", {{(64-LW){1'b0}}, fifo_level}, 4);
    check("t2_corner_count", {48'd0, corner_count}, 6);
    check("t2_drop_count", {48'd0, drop_count}, 2);
    step(0, 0, 1, 50, 9, 1, 0, 1);
    check("t2_full_push_level", {{(64-LW){1'b0}}, fifo_level}, 4);
    check("t2_full_push_drop", {48'd0, drop_count}, 2);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    drain();

    // all-negative scores, tie keeps first
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, -7, 10, 2, 0, 1);
    step(0, 0, 1, -3, 11, 2, 0, 1);
    step(0, 0, 1, -3, 12, 2, 0, 1);
    check("t3_max_valid", {63'd0, max_valid}, 1);
    check("t3_max_score", max_score, -64'sd3);
    check("t3_max_x", {48'd0, max_x}, 11);

    // start+end together restarts the frame without frame_done
    step(0, 0, 1, 500, 1, 1, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    check("t4_no_done", {63'd0, frame_done}, 0);
    check("t4_cleared", {48'd0, corner_count}, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    check("t4_done", {63'd0, frame_done}, 1);
    idle(1);
    drain();

    // reset mid-frame with 3 records buffered
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 20 + i, i, 3, 0, 0);
    check("t5_buffered", {{(64-LW){1'b0}}, fifo_level}, 3);
    do_reset();
    check("t5_out_valid", {63'd0, out_valid}, 0);
    check("t5_corner_count", {48'd0, corner_count}, 0);
    step(0, 1, 1, 900, 5, 5, 0, 1);
    check("t5_idle_no_done", {63'd0, frame_done}, 0);

    // randomized frames
    for (int f = 0; f < 80; f++) begin
      thr = longint'($urandom_range(0, 400)) - 64'sd200;
      if ($urandom_range(0, 9) == 0) thr = rnd_score();
      step(1, 0, $urandom_range(0, 1) == 1, rnd_score(), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)), thr, $urandom_range(0, 1) == 1);
      len = int'($urandom_range(3, 30));
      for (int i = 0; i < len; i++) begin
        fs = ($urandom_range(0, 29) == 0);
        fe = fs && ($urandom_range(0, 1) == 1);
        step(fs, fe, $urandom_range(0, 3) != 0, rnd_score(), int'($urandom_range(0, 65535)),
             int'($urandom_range(0, 65535)), rnd_score(), $urandom_range(0, 1) == 1);
      end
      step(0, 1, $urandom_range(0, 1) == 1, rnd_score(), int'($urandom_range(0, 65535)),
           int'($urandom_range(0, 65535)), rnd_score(), $urandom_range(0, 1) == 1);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, rnd_score(), 1, 1,
             rnd_score(), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 14) == 0) do_reset();
    end
    drain();
    check("leftover_records", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
